// File: rtl/telemetry_packetizer.sv
// Snapshots up to NUM_CH sensor channels and serialises each snapshot as a framed,
// checksummed byte stream over the serial_tx data/new_data/busy/block handshake.
module telemetry_packetizer #(
    parameter int          NUM_CH   = 8,
    parameter int          CH_BYTES = 2,
    parameter int          PERIOD   = 500000,
    parameter logic [7:0]  SYNC0    = 8'hA5,
    parameter logic [7:0]  SYNC1    = 8'h5A
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH*CH_BYTES*8-1:0]   ch_data,
    input  logic [NUM_CH-1:0]              ch_enable,
    input  logic                           trigger,
    input  logic                           periodic_en,
    output logic [7:0]                     tx_data,
    output logic                           new_tx_data,
    input  logic                           tx_busy,
    input  logic                           tx_block,
    output logic                           frame_busy,
    output logic [15:0]                    frame_count,
    output logic                           overrun
);

    localparam int DW = NUM_CH * CH_BYTES * 8;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SNAP = 3'd1;
    localparam logic [2:0] S_EMIT = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [2:0] P_SYNC0 = 3'd0;
    localparam logic [2:0] P_SYNC1 = 3'd1;
    localparam logic [2:0] P_SEQ   = 3'd2;
    localparam logic [2:0] P_MASK  = 3'd3;
    localparam logic [2:0] P_DATA  = 3'd4;
    localparam logic [2:0] P_CSUM  = 3'd5;
    localparam logic [2:0] P_END   = 3'd6;

    logic [2:0]        state;
    logic [2:0]        phase;
    logic [31:0]       period_cnt;
    logic              tick;
    logic              request;
    logic [DW-1:0]     snap_data;
    logic [NUM_CH-1:0] snap_mask;
    logic [7:0]        snap_seq;
    logic [7:0]        seq;
    logic [7:0]        sum;
    logic [2:0]        ch_idx;
    logic [1:0]        byte_idx;
    logic [7:0]        cur_byte;
    logic              link_free;
    logic [3:0]        first_ch;
    logic [3:0]        next_ch;
    logic [2:0]        n_phase;
    logic [2:0]        n_ch;
    logic [1:0]        n_byte;

    // Returns {found, index} of the lowest enabled channel at or above start.
    function automatic logic [3:0] find_next(input logic [NUM_CH-1:0] m, input int start);
        logic [3:0] r;
        r = 4'h0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!r[3] && i >= start && m[i])
                r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    assign tick      = periodic_en && (period_cnt == 32'(PERIOD - 1));
    assign request   = trigger || tick;
    assign link_free = !tx_busy && !tx_block;
    assign first_ch  = find_next(snap_mask, 0);
    assign next_ch   = find_next(snap_mask, int'(ch_idx) + 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            period_cnt <= 32'd0;
        else if (!periodic_en || tick)
            period_cnt <= 32'd0;
        else
            period_cnt <= period_cnt + 32'd1;
    end

    // NOTE: every signal assigned in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        cur_byte = 8'h00;
        case (phase)
            P_SYNC0: cur_byte = SYNC0;
            P_SYNC1: cur_byte = SYNC1;
            P_SEQ:   cur_byte = snap_seq;
            P_MASK:  cur_byte = 8'(snap_mask);
            P_DATA:  cur_byte = snap_data[(int'(ch_idx) * CH_BYTES + CH_BYTES - 1 - int'(byte_idx)) * 8 +: 8];
            P_CSUM:  cur_byte = 8'h00 - sum;
            default: cur_byte = 8'h00;
        endcase
    end

    // Pointer advance after a byte is emitted; skips disabled channels entirely.
    always_comb begin
        n_phase = phase;
        n_ch    = ch_idx;
        n_byte  = byte_idx;
        case (phase)
            P_SYNC0: n_phase = P_SYNC1;
            P_SYNC1: n_phase = P_SEQ;
            P_SEQ:   n_phase = P_MASK;
            P_MASK: begin
                if (first_ch[3]) begin
                    n_phase = P_DATA;
                    n_ch    = first_ch[2:0];
                    n_byte  = 2'd0;
                end else begin
                    n_phase = P_CSUM;
                end
            end
            P_DATA: begin
                if (byte_idx == 2'(CH_BYTES - 1)) begin
                    if (next_ch[3]) begin
                        n_ch   = next_ch[2:0];
                        n_byte = 2'd0;
                    end else begin
                        n_phase = P_CSUM;
                    end
                end else begin
                    n_byte = byte_idx + 2'd1;
                end
            end
            P_CSUM:  n_phase = P_END;
            default: n_phase = phase;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            phase       <= P_SYNC0;
            snap_data   <= '0;
            snap_mask   <= '0;
            snap_seq    <= 8'h00;
            seq         <= 8'h00;
            sum         <= 8'h00;
            ch_idx      <= 3'd0;
            byte_idx    <= 2'd0;
            tx_data     <= 8'h00;
            new_tx_data <= 1'b0;
            frame_busy  <= 1'b0;
            frame_count <= 16'h0000;
            overrun     <= 1'b0;
        end else begin
            new_tx_data <= 1'b0;
            overrun     <= request && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (request)
                        state <= S_SNAP;
                end
                S_SNAP: begin
                    snap_data  <= ch_data;
                    snap_mask  <= ch_enable;
                    snap_seq   <= seq;
                    frame_busy <= 1'b1;
                    phase      <= P_SYNC0;
                    ch_idx     <= 3'd0;
                    byte_idx   <= 2'd0;
                    sum        <= 8'h00;
                    state      <= S_EMIT;
                end
                S_EMIT: begin
                    if (link_free) begin
                        tx_data     <= cur_byte;
                        new_tx_data <= 1'b1;
                        phase       <= n_phase;
                        ch_idx      <= n_ch;
                        byte_idx    <= n_byte;
                        if (phase == P_SEQ || phase == P_MASK || phase == P_DATA)
                            sum <= sum + cur_byte;
                        state <= S_WAIT;
                    end
                end
                // serial_tx raises busy one cycle late, so this cycle never looks at it.
                S_WAIT: begin
                    state <= (phase == P_END) ? S_DONE : S_EMIT;
                end
                S_DONE: begin
                    frame_busy  <= 1'b0;
                    frame_count <= frame_count + 16'd1;
                    seq         <= seq + 8'd1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_telemetry_packetizer.sv
// Self-checking bench for telemetry_packetizer: randomized frames compared against a
// frame-level reference model, plus directed timing, overrun, stall and reset scenarios.
module tb_telemetry_packetizer;

    localparam int NUM_CH   = 8;
    localparam int CH_BYTES = 2;
    localparam int PERIOD   = 100;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] ch_data = '0;
    logic [7:0]   ch_enable = '0;
    logic         trigger = 1'b0;
    logic         periodic_en = 1'b0;
    logic         tx_block = 1'b0;
    logic         tx_busy;
    logic [7:0]   tx_data;
    logic         new_tx_data;
    logic         frame_busy;
    logic [15:0]  frame_count;
    logic         overrun;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ovr_cnt = 0;
    int rise_cnt = 0;
    int bcnt = 0;
    logic prev_busy = 1'b0;
    logic slow = 1'b0;
    int rise_q[$];
    logic [7:0] cap[$];
    logic [7:0] exp_q[$];
    logic [7:0] lit[$];
    logic [7:0]  exp_seq = 8'h00;
    logic [15:0] exp_count = 16'h0000;

    telemetry_packetizer #(
        .NUM_CH(NUM_CH), .CH_BYTES(CH_BYTES), .PERIOD(PERIOD), .SYNC0(8'hA5), .SYNC1(8'h5A)
    ) dut (
        .clk(clk), .rst(rst), .ch_data(ch_data), .ch_enable(ch_enable), .trigger(trigger),
        .periodic_en(periodic_en), .tx_data(tx_data), .new_tx_data(new_tx_data),
        .tx_busy(tx_busy), .tx_block(tx_block), .frame_busy(frame_busy),
        .frame_count(frame_count), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // serial_tx stand-in: busy for 3 cycles after each accepted byte when slow is set.
    always @(posedge clk or posedge rst) begin
        if (rst)                     bcnt <= 0;
        else if (slow && new_tx_data) bcnt <= 3;
        else if (bcnt > 0)           bcnt <= bcnt - 1;
    end
    assign tx_busy = (bcnt != 0);

    always @(negedge clk) begin
        if (new_tx_data) cap.push_back(tx_data);
        if (overrun) ovr_cnt <= ovr_cnt + 1;
        if (frame_busy && !prev_busy) begin
            rise_cnt <= rise_cnt + 1;
            rise_q.push_back(cyc);
        end
        prev_busy <= frame_busy;
    end

    // Reference model: appends one whole frame built from the byte-order and checksum rules.
    task automatic add_expected(input logic [7:0] sq, input logic [7:0] m, input logic [127:0] d);
        int total;
        logic [7:0] v;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(sq);
        exp_q.push_back(m);
        total = int'(sq) + int'(m);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (m[ch]) begin
                for (int b = 0; b < CH_BYTES; b++) begin
                    v = d[ch * CH_BYTES * 8 + (CH_BYTES - 1 - b) * 8 +: 8];
                    exp_q.push_back(v);
                    total += int'(v);
                end
            end
        end
        exp_q.push_back(8'((256 - (total % 256)) % 256));
    endtask

    function automatic string fmt(input logic [7:0] q[$]);
        string s;
        s = "";
        foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
        return s;
    endfunction

    function automatic bit same(input logic [7:0] a[$], input logic [7:0] b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic pulse_trigger();
        @(negedge clk) trigger = 1'b1;
        @(negedge clk) trigger = 1'b0;
    endtask

    task automatic wait_frames(input int start, input int n, input int bound);
        int i;
        i = 0;
        while (!((rise_cnt - start) >= n && !frame_busy) && i < bound) begin
            @(negedge clk);
            i++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (i >= bound) begin
            errors++;
            $display("FAIL frame_timeout: saw %0d frame starts, needed %0d within %0d cycles", rise_cnt - start, n, bound);
        end
    endtask

    task automatic wait_bytes(input int n, input int bound);
        int i;
        i = 0;
        while (cap.size() < n && i < bound) begin
            @(negedge clk);
            i++;
        end
        checks++;
        if (cap.size() < n) begin
            errors++;
            $display("FAIL byte_timeout: got %0d bytes, needed %0d", cap.size(), n);
        end
    endtask

    task automatic test_reset();
        checks += 5;
        if (tx_data !== 8'h00)       begin errors++; $display("FAIL reset_tx_data: got %02h want 00", tx_data); end
        if (new_tx_data !== 1'b0)    begin errors++; $display("FAIL reset_new_tx_data: got %b want 0", new_tx_data); end
        if (frame_busy !== 1'b0)     begin errors++; $display("FAIL reset_frame_busy: got %b want 0", frame_busy); end
        if (frame_count !== 16'h0)   begin errors++; $display("FAIL reset_frame_count: got %04h want 0000", frame_count); end
        if (overrun !== 1'b0)        begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_basic();
        int start;
        slow = 1'b1;
        ch_enable = 8'h05;
        ch_data = '0;
        ch_data[15:0] = 16'h1234;
        ch_data[47:32] = 16'hABCD;
        cap.delete(); exp_q.delete();
        add_expected(exp_seq, ch_enable, ch_data);
        lit = '{8'hA5, 8'h5A, 8'h00, 8'h05, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h3D};
        start = rise_cnt;
        pulse_trigger();
        wait_frames(start, 1, 400);
        exp_seq++; exp_count++;
        checks += 4;
        if (!same(cap, lit))   begin errors++; $display("FAIL basic_bytes: got %s want %s", fmt(cap), fmt(lit)); end
        if (!same(cap, exp_q)) begin errors++; $display("FAIL basic_model: got %s want %s", fmt(cap), fmt(exp_q)); end
        if (frame_count !== exp_count) begin errors++; $display("FAIL basic_count: got %0d want %0d", frame_count, exp_count); end
        if (frame_busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b want 0", frame_busy); end
    endtask

    task automatic test_random(input int n);
        int start;
        for (int k = 0; k < n; k++) begin
            slow = 1'($urandom_range(0, 1));
            ch_enable = 8'($urandom);
            ch_data = {$urandom, $urandom, $urandom, $urandom};
            cap.delete(); exp_q.delete();
            add_expected(exp_seq, ch_enable, ch_data);
            start = rise_cnt;
            pulse_trigger();
            wait_frames(start, 1, 600);
            exp_seq++; exp_count++;
            checks += 2;
            if (!same(cap, exp_q)) begin errors++; $display("FAIL random_bytes[%0d]: got %s want %s", k, fmt(cap), fmt(exp_q)); end
            if (frame_count !== exp_count) begin errors++; $display("FAIL random_count[%0d]: got %0d want %0d", k, frame_count, exp_count); end
        end
    endtask

    task automatic test_empty_mask();
        int start;
        slow = 1'b0;
        ch_enable = 8'h00;
        ch_data = {$urandom, $urandom, $urandom, $urandom};
        cap.delete();
        lit = '{8'hA5, 8'h5A, 8'h03, 8'h00, 8'hFD};
        start = rise_cnt;
        pulse_trigger();
        wait_frames(start, 1, 200);
        exp_seq++; exp_count++;
        checks += 2;
        if (!same(cap, lit)) begin errors++; $display("FAIL empty_bytes: got %s want %s", fmt(cap), fmt(lit)); end
        if (cap.size() != 5) begin errors++; $display("FAIL empty_strobes: got %0d want 5", cap.size()); end
    endtask

    task automatic test_overrun();
        int start, ovr0;
        slow = 1'b1;
        ch_enable = 8'hFF;
        ch_data = {$urandom, $urandom, $urandom, $urandom};
        cap.delete(); exp_q.delete();
        add_expected(exp_seq, ch_enable, ch_data);
        ovr0 = ovr_cnt;
        start = rise_cnt;
        pulse_trigger();
        wait_bytes(2, 200);
        pulse_trigger();
        wait_frames(start, 1, 2000);
        repeat (40) @(negedge clk);
        exp_seq++; exp_count++;
        checks += 4;
        if (ovr_cnt - ovr0 != 1) begin errors++; $display("FAIL overrun_pulses: got %0d want 1", ovr_cnt - ovr0); end
        if (!same(cap, exp_q)) begin errors++; $display("FAIL overrun_bytes: got %s want %s", fmt(cap), fmt(exp_q)); end
        if (rise_cnt - start != 1) begin errors++; $display("FAIL overrun_frames: got %0d want 1", rise_cnt - start); end
        if (frame_count !== exp_count) begin errors++; $display("FAIL overrun_count: got %0d want %0d", frame_count, exp_count); end
    endtask

    task automatic test_snapshot();
        int start;
        slow = 1'b1;
        ch_enable = 8'($urandom) | 8'h01;
        ch_data = {$urandom, $urandom, $urandom, $urandom};
        cap.delete(); exp_q.delete();
        add_expected(exp_seq, ch_enable, ch_data);
        start = rise_cnt;
        pulse_trigger();
        @(negedge clk);
        ch_data = ~ch_data;
        ch_enable = ~ch_enable;
        checks++;
        if (frame_busy !== 1'b1) begin errors++; $display("FAIL snap_busy: got %b want 1", frame_busy); end
        wait_frames(start, 1, 1000);
        exp_seq++; exp_count++;
        checks++;
        if (!same(cap, exp_q)) begin errors++; $display("FAIL snap_bytes: got %s want %s", fmt(cap), fmt(exp_q)); end
    endtask

    task automatic test_tx_block();
        int start, n0;
        slow = 1'b0;
        ch_enable = 8'hFF;
        ch_data = {$urandom, $urandom, $urandom, $urandom};
        cap.delete(); exp_q.delete();
        add_expected(exp_seq, ch_enable, ch_data);
        start = rise_cnt;
        pulse_trigger();
        wait_bytes(3, 100);
        tx_block = 1'b1;
        @(negedge clk);
        n0 = cap.size();
        repeat (19) @(negedge clk);
        checks += 2;
        if (cap.size() != n0) begin errors++; $display("FAIL block_hold: got %0d bytes during hold want %0d", cap.size(), n0); end
        if (frame_busy !== 1'b1) begin errors++; $display("FAIL block_busy: got %b want 1", frame_busy); end
        tx_block = 1'b0;
        wait_frames(start, 1, 400);
        exp_seq++; exp_count++;
        checks++;
        if (!same(cap, exp_q)) begin errors++; $display("FAIL block_bytes: got %s want %s", fmt(cap), fmt(exp_q)); end
    endtask

    task automatic test_periodic();
        int start, c0, c1, r, ovr0;
        slow = 1'b0;
        ch_enable = 8'($urandom);
        ch_data = {$urandom, $urandom, $urandom, $urandom};
        cap.delete(); exp_q.delete(); rise_q.delete();
        for (int k = 0; k < 3; k++) add_expected(exp_seq + 8'(k), ch_enable, ch_data);
        start = rise_cnt;
        @(negedge clk);
        c0 = cyc;
        periodic_en = 1'b1;
        wait_frames(start, 3, 500);
        periodic_en = 1'b0;
        exp_seq += 8'd3; exp_count += 16'd3;
        checks += 4;
        if (rise_q.size() < 3) begin
            errors++; $display("FAIL periodic_starts: got %0d want 3", rise_q.size());
        end else begin
            if (rise_q[0] - c0 < PERIOD || rise_q[0] - c0 > PERIOD + 2) begin errors++; $display("FAIL periodic_first: got %0d want %0d..%0d", rise_q[0] - c0, PERIOD, PERIOD + 2); end
            if (rise_q[1] - rise_q[0] != PERIOD) begin errors++; $display("FAIL periodic_gap1: got %0d want %0d", rise_q[1] - rise_q[0], PERIOD); end
            if (rise_q[2] - rise_q[1] != PERIOD) begin errors++; $display("FAIL periodic_gap2: got %0d want %0d", rise_q[2] - rise_q[1], PERIOD); end
        end
        if (!same(cap, exp_q)) begin errors++; $display("FAIL periodic_bytes: got %s want %s", fmt(cap), fmt(exp_q)); end

        start = rise_cnt;
        repeat (50) @(negedge clk);
        checks++;
        if (rise_cnt != start) begin errors++; $display("FAIL periodic_disabled: got %0d frames want 0", rise_cnt - start); end

        cap.delete(); exp_q.delete(); rise_q.delete();
        add_expected(exp_seq, ch_enable, ch_data);
        add_expected(exp_seq + 8'd1, ch_enable, ch_data);
        @(negedge clk);
        c1 = cyc;
        periodic_en = 1'b1;
        wait_frames(start, 1, 300);
        checks++;
        if (rise_q.size() < 1) begin
            errors++; $display("FAIL reenable_start: got 0 frames want 1");
        end else begin
            if (rise_q[0] - c1 < PERIOD || rise_q[0] - c1 > PERIOD + 2) begin errors++; $display("FAIL reenable_delay: got %0d want %0d..%0d", rise_q[0] - c1, PERIOD, PERIOD + 2); end
            // Land the trigger on the same clock as the next internal tick.
            r = rise_q[0];
            ovr0 = ovr_cnt;
            while (cyc < r + PERIOD - 2) @(negedge clk);
            trigger = 1'b1;
            @(negedge clk);
            trigger = 1'b0;
            periodic_en = 1'b0;
            start = rise_cnt;
            wait_frames(start, 1, 300);
            repeat (PERIOD + 10) @(negedge clk);
            checks += 3;
            if (ovr_cnt != ovr0) begin errors++; $display("FAIL coincide_overrun: got %0d pulses want 0", ovr_cnt - ovr0); end
            if (rise_q.size() != 2) begin errors++; $display("FAIL coincide_frames: got %0d starts want 2", rise_q.size()); end
            else if (rise_q[1] - rise_q[0] != PERIOD) begin errors++; $display("FAIL coincide_gap: got %0d want %0d", rise_q[1] - rise_q[0], PERIOD); end
            if (!same(cap, exp_q)) begin errors++; $display("FAIL coincide_bytes: got %s want %s", fmt(cap), fmt(exp_q)); end
        end
        exp_seq += 8'd2; exp_count += 16'd2;
    endtask

    task automatic test_reset_midframe();
        int start;
        slow = 1'b1;
        ch_enable = 8'($urandom) | 8'h10;
        ch_data = {$urandom, $urandom, $urandom, $urandom};
        cap.delete();
        pulse_trigger();
        wait_bytes(4, 200);
        rst = 1'b1;
        #1;
        test_reset();
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        exp_seq = 8'h00; exp_count = 16'h0000;
        cap.delete();
        repeat (40) @(negedge clk);
        checks += 2;
        if (cap.size() != 0) begin errors++; $display("FAIL reset_abandon: got %0d bytes want 0", cap.size()); end
        if (frame_busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", frame_busy); end

        ch_enable = 8'($urandom);
        ch_data = {$urandom, $urandom, $urandom, $urandom};
        cap.delete(); exp_q.delete();
        add_expected(exp_seq, ch_enable, ch_data);
        start = rise_cnt;
        pulse_trigger();
        wait_frames(start, 1, 600);
        exp_seq++; exp_count++;
        checks += 3;
        if (!same(cap, exp_q)) begin errors++; $display("FAIL post_reset_bytes: got %s want %s", fmt(cap), fmt(exp_q)); end
        if (cap.size() < 3 || cap[2] !== 8'h00) begin errors++; $display("FAIL post_reset_seq: got %s want seq 00", fmt(cap)); end
        if (frame_count !== 16'd1) begin errors++; $display("FAIL post_reset_count: got %0d want 1", frame_count); end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        test_basic();
        test_random(2);
        test_empty_mask();
        test_random(6);
        test_overrun();
        test_snapshot();
        test_tx_block();
        test_periodic();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/telemetry_packetizer.md
Name: telemetry_packetizer

Overview:
Parametrised successor to the fixed sensor-register to data-link path. It snapshots up to NUM_CH sensor channels atomically, either on a periodic tick or on demand. Each snapshot is serialised into a framed, checksummed byte stream: sync, sequence, channel mask, selected channel data and checksum. The block drives the existing serial_tx handshake (data/new_data/busy/block) and sits between the sensor controllers and the downlink UART.

Parameters:
NUM_CH, 8, number of input channels (1..8).
CH_BYTES, 2, bytes per channel (1..4), sent MSB first.
PERIOD, 500000, clocks between periodic frames (10 ms at 50 MHz); must be >= 2.
SYNC0, 8'hA5, first sync byte.
SYNC1, 8'h5A, second sync byte.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
ch_data  in  NUM_CH*CH_BYTES*8  channel i occupies bits [(i+1)*CH_BYTES*8-1 : i*CH_BYTES*8]
ch_enable  in  NUM_CH  channel include mask, sampled at snapshot
trigger  in  1  single-cycle request for an immediate frame
periodic_en  in  1  enables the internal PERIOD timer
tx_data  out  8  byte to serial_tx
new_tx_data  out  1  one-cycle strobe qualifying tx_data
tx_busy  in  1  serial_tx busy
tx_block  in  1  downstream flow-control hold
frame_busy  out  1  high from snapshot until the checksum byte is accepted
frame_count  out  16  completed frames, wraps at 16'hFFFF -> 0
overrun  out  1  one-cycle pulse when a frame request is dropped

Behaviour:
- Reset (async, any state): state IDLE, period counter 0, frame_count 0, seq 0, tx_data 8'h00, new_tx_data 0, frame_busy 0, overrun 0. A partial frame is abandoned. Nothing further is emitted for it.
- Period timer: runs while periodic_en=1, counting 0..PERIOD-1. At PERIOD-1 it wraps and raises an internal tick for one cycle. While periodic_en=0 it is held at 0.
- Request = trigger OR tick. A simultaneous trigger and tick produce one frame and no overrun.
- A request while frame_busy=1 is dropped and pulses overrun in the next cycle. The frame in flight is unaffected.
- States: IDLE -> SNAP -> EMIT <-> WAIT -> ... -> DONE -> IDLE.
  - IDLE: on a request, go to SNAP.
  - SNAP: latch ch_data, ch_enable and seq into the shadow registers; set frame_busy=1. Input changes after this edge do not affect the frame.
  - EMIT: when tx_busy=0 and tx_block=0, drive tx_data with the current byte and pulse new_tx_data for exactly 1 cycle, then go to WAIT. Otherwise hold with new_tx_data=0.
  - WAIT: ignore tx_busy for 1 cycle (serial_tx busy lags by one cycle). Then return to EMIT for the next byte, or go to DONE after the checksum byte.
  - DONE: frame_busy=0, frame_count+1, seq+1 (8-bit wrap). Return to IDLE.
- Latency: request sampled at edge N, SNAP at N+1, first new_tx_data at N+2 if the link is free.
- Byte order:
  - SYNC0, SYNC1.
  - seq.
  - mask: the ch_enable snapshot, zero-extended to 8 bits.
  - For each enabled channel in ascending index: CH_BYTES bytes, MSB first.
  - checksum.
  - Disabled channels emit nothing.
- Frame length = 5 + CH_BYTES*popcount(mask) bytes.
- Checksum: 8-bit two's complement of the modulo-256 sum of all bytes from seq through the last data byte. That sum plus the checksum is 0 mod 256. Sync bytes are excluded.
- Mask = 0 gives a valid 5-byte frame: SYNC0, SYNC1, seq, 00, checksum.
- Highest-index enabled channel: after its last byte the checksum follows directly, with no idle cycles beyond the normal WAIT.
- tx_block asserted mid-frame: emission stalls between bytes, never mid-byte. It resumes on deassertion and the byte sequence is unchanged.

Test Plan:
- Reset, mask 8'h05, ch0=16'h1234, ch2=16'hABCD, pulse trigger, serial_tx model with 3-cycle busy -> bytes A5 5A 00 05 12 34 AB CD 3D. frame_count=1, frame_busy low after the last accept.
- Mask 8'h00, seq at 3 (after 3 prior frames), trigger -> A5 5A 03 00 FD. Exactly 5 new_tx_data pulses.
- PERIOD=100, periodic_en=1, fast link -> frames start 100 clocks apart. periodic_en=0 for 50 cycles then 1 -> next frame 100 clocks after re-enable.
- Trigger again while frame_busy=1 -> overrun pulses once. The current frame is unchanged and no second frame is sent. Trigger and tick on the same cycle -> one frame, no overrun.
- Change ch_data on the cycle after SNAP -> the emitted frame carries the pre-change values. Hold tx_block=1 for 20 cycles mid-frame -> no new_tx_data during the hold, identical byte sequence after release.
- Assert rst after the 4th byte -> outputs at reset values immediately. The next trigger yields a full frame with seq 00 and frame_count counting from 0.
